// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between fetch (0), load/store (1) and debug (2).
// One grant per cycle, round-robin with a bounded lock for bursts; reads return
// one cycle after the grant.
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 24,
    parameter int MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            rst_n,      // active-high synchronous reset
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [2:0]      lock,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [1:0]    last_gnt;
    logic [1:0]    lock_own;
    logic          lock_act;
    logic [CW-1:0] lock_cnt;
    logic [2:0]    rv_pipe;

    logic          lock_hold;
    logic          any_gnt;
    logic [1:0]    gidx;
    logic [1:0]    p1, p2, p3;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Arbitration: lock hold first, otherwise round-robin after the last grant.
    // When a lock run has expired the owner is last_gnt, so it naturally drops
    // to lowest priority in the round-robin search.
    always_comb begin
        lock_hold = 1'b0;
        any_gnt   = 1'b0;
        gidx      = 2'd0;
        p1        = next_port(last_gnt);
        p2        = next_port(p1);
        p3        = next_port(p2);
        if (!rst_n) begin
            lock_hold = lock_act && req[lock_own] && lock[lock_own] &&
                        (lock_cnt < CW'(MAX_LOCK));
            if (lock_hold) begin
                any_gnt = 1'b1;
                gidx    = lock_own;
            end else if (req[p1]) begin
                any_gnt = 1'b1;
                gidx    = p1;
            end else if (req[p2]) begin
                any_gnt = 1'b1;
                gidx    = p2;
            end else if (req[p3]) begin
                any_gnt = 1'b1;
                gidx    = p3;
            end
        end
    end

    // Memory-side mux of the granted port; all zero when nothing is granted.
    always_comb begin
        gnt       = 3'b000;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt) begin
            gnt       = 3'b001 << gidx;
            mem_en    = 1'b1;
            mem_we    = we[gidx];
            mem_addr  = addr[gidx*AW +: AW];
            mem_wdata = wdata[gidx*DW +: DW];
        end
    end

    // Arbitration state: last grant, lock ownership and lock run length.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_gnt <= 2'd2;
            lock_own <= 2'd0;
            lock_act <= 1'b0;
            lock_cnt <= '0;
        end else if (any_gnt) begin
            last_gnt <= gidx;
            if (!lock[gidx]) begin
                lock_act <= 1'b0;
            end else if (lock_hold) begin
                lock_cnt <= lock_cnt + CW'(1);
            end else begin
                lock_act <= 1'b1;
                lock_own <= gidx;
                lock_cnt <= CW'(1);
            end
        end else begin
            lock_act <= 1'b0;
        end
    end

    // Read-valid pipeline: one cycle behind read grants, writes excluded.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rv_pipe <= 3'b000;
        end else begin
            rv_pipe <= gnt & ~{3{mem_we}};
        end
    end

    // A read granted just before reset must not surface during reset.
    assign rvalid = rv_pipe & ~{3{rst_n}};
    assign rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (MAX_LOCK = 4) with a small memory model.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      req, we, lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: preload pattern plus a single written word overlay.
    function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
        return {8'hC3, a, ~a};
    endfunction

    logic          wr_v = 1'b0;
    logic [AW-1:0] wr_a = '0;
    logic [DW-1:0] wr_d = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                wr_v <= 1'b1;
                wr_a <= mem_addr;
                wr_d <= mem_wdata;
            end else begin
                mem_rdata <= (wr_v && wr_a == mem_addr) ? wr_d : pre(mem_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2);
        addr = {a2, a1, a0};
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = 3'b111; we = 3'b000; lock = 3'b000;
        set_addrs(8'h00, 8'h00, 8'h00); wdata = '0;
        tick(); tick(); #4;
        checks++;
        if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        checks++;
        if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
        tick();
        rst_n = 1'b0; req = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [2:0]    exp_g [6];
        logic [2:0]    prev_g;
        logic [AW-1:0] prev_a;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        prev_g = 3'b000;
        prev_a = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            req = 3'b111; we = 3'b000; set_addrs(8'h20, 8'h21, 8'h22);
            #4;
            checks++;
            if (gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
            if (i > 0) begin
                checks++;
                if (rvalid !== prev_g || rdata !== pre(prev_a)) begin
                    errors++;
                    $display("FAIL rr_rvalid[%0d]: got %b/%h expected %b/%h", i, rvalid, rdata, prev_g, pre(prev_a));
                end
            end
            prev_g = exp_g[i];
            prev_a = 8'h20 + AW'(i % 3);
        end
        tick();
        req = 3'b000;
        #4;
        checks++;
        if (rvalid !== 3'b100 || rdata !== pre(8'h22)) begin
            errors++;
            $display("FAIL rr_last_rvalid: got %b/%h expected 100/%h", rvalid, rdata, pre(8'h22));
        end
    endtask

    task automatic test_write_read();
        tick();
        req = 3'b010; we = 3'b010; set_addrs(8'h10, 8'h10, 8'h00);
        wdata = {24'h0, 24'hABCDEF, 24'h0};
        #4;
        checks++;
        if (gnt !== 3'b010 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 24'hABCDEF) begin
            errors++;
            $display("FAIL wr_cycle: got gnt=%b we=%b a=%h d=%h expected 010/1/10/abcdef", gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        req = 3'b001; we = 3'b000;
        #4;
        checks++;
        if (gnt !== 3'b001 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_gnt: got %b we=%b expected 001 we=0", gnt, mem_we); end
        checks++;
        if (rvalid !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 000", rvalid); end
        tick();
        req = 3'b000;
        #4;
        checks++;
        if (rvalid !== 3'b001 || rdata !== 24'hABCDEF) begin
            errors++;
            $display("FAIL rd_data: got %b/%h expected 001/abcdef", rvalid, rdata);
        end
    endtask

    task automatic test_lock_expiry();
        logic [2:0] exp_g [8];
        exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
        for (int i = 0; i < 8; i++) begin
            tick();
            req = (i == 0) ? 3'b100 : 3'b111; lock = 3'b100; we = 3'b000;
            #4;
            checks++;
            if (gnt !== exp_g[i]) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
        end
        tick();
        req = 3'b000; lock = 3'b000;
    endtask

    task automatic test_lock_drop();
        logic [2:0] exp_g [4];
        exp_g = '{3'b010, 3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 4; i++) begin
            tick();
            req  = (i == 0) ? 3'b010 : 3'b111;
            lock = (i < 2) ? 3'b010 : 3'b000;
            #4;
            checks++;
            if (gnt !== exp_g[i]) begin errors++; $display("FAIL lockdrop_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
        end
        tick();
        req = 3'b000; lock = 3'b000;
    endtask

    task automatic test_reset_mid();
        tick();
        req = 3'b001; we = 3'b000;
        #4;
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL rstmid_gnt: got %b expected 001", gnt); end
        tick();
        rst_n = 1'b1;
        #4;
        checks++;
        if (rvalid !== 3'b000 || gnt !== 3'b000 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: got rvalid=%b gnt=%b en=%b expected 000/000/0", rvalid, gnt, mem_en);
        end
        tick();
        rst_n = 1'b0; req = 3'b111;
        #4;
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL rstmid_prio: got %b expected 001", gnt); end
        checks++;
        if (rvalid !== 3'b000) begin errors++; $display("FAIL rstmid_rvalid: got %b expected 000", rvalid); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            req = 3'b000;
            #4;
            checks++;
            if (gnt !== 3'b000 || mem_en !== 1'b0 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: got gnt=%b en=%b a=%h we=%b expected all zero", i, gnt, mem_en, mem_addr, mem_we);
            end
            checks++;
            if (rvalid !== ((i == 0) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL idle_rvalid[%0d]: got %b expected %b", i, rvalid, (i == 0) ? 3'b001 : 3'b000);
            end
        end
        tick();
        req = 3'b111;
        #4;
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL idle_resume: got %b expected 010", gnt); end
        tick();
        req = 3'b000;
    endtask

    initial begin
        rst_n = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock_expiry();
        test_lock_drop();
        test_reset_mid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
